// File: rtl/eps_ctrl.sv
// eps_ctrl: sequencing controller for the epsilon estimator.
// Fills an external 256-entry angle buffer, accepts an argmax index once the
// buffer is full, strobes select_eps for exactly one cycle and hands the
// selected epsilon to the downstream consumer through a valid/ready port.
// The buffer write pointer is frozen while select_eps evaluates so that the
// evaluation sees a consistent buffer.
module eps_ctrl #(
  parameter int ANG_W   = 16,
  parameter int THETA_W = 8,
  parameter int EPS_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  // angle sample stream
  input  logic               ang_valid,
  output logic               ang_ready,
  input  logic [ANG_W-1:0]   ang_in,
  // external angle buffer write port
  output logic               wr_en,
  output logic [7:0]         wr_addr,
  output logic [ANG_W-1:0]   wr_data,
  output logic [7:0]         write_ptr,
  output logic               buf_valid,
  // argmax index stream
  input  logic               theta_valid,
  output logic               theta_ready,
  input  logic [THETA_W-1:0] theta_in,
  // select_eps interface
  output logic [THETA_W-1:0] theta_q,
  output logic               argmax_valid,
  input  logic [EPS_W-1:0]   sel_eps,
  input  logic               sel_valid,
  // estimate output stream
  output logic               eps_valid,
  input  logic               eps_ready,
  output logic [EPS_W-1:0]   eps_data,
  output logic [15:0]        eps_cnt,
  output logic               sel_err
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_EVAL  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [8:0] FILL_FULL = 9'd256;

  state_t             state_q,    state_d;
  logic [7:0]         write_ptr_q, write_ptr_d;
  logic [8:0]         fill_cnt_q, fill_cnt_d;
  logic [THETA_W-1:0] theta_d;
  logic [EPS_W-1:0]   eps_data_q, eps_data_d;
  logic [15:0]        eps_cnt_q,  eps_cnt_d;
  logic               sel_err_q,  sel_err_d;

  logic               ang_ready_s;
  logic               theta_ready_s;
  logic               argmax_valid_s;
  logic               eps_valid_s;
  logic               wr_en_s;
  logic               theta_xfer_s;
  logic               eps_xfer_s;

  // Handshake outputs decoded from state; flush silences every handshake.
  always_comb begin
    ang_ready_s    = 1'b0;
    theta_ready_s  = 1'b0;
    argmax_valid_s = 1'b0;
    eps_valid_s    = 1'b0;
    case (state_q)
      ST_FILL: begin
        ang_ready_s = 1'b1;
      end
      ST_ARMED: begin
        ang_ready_s   = 1'b1;
        theta_ready_s = 1'b1;
      end
      ST_EVAL: begin
        argmax_valid_s = 1'b1;
      end
      ST_OUT: begin
        ang_ready_s = 1'b1;
        eps_valid_s = 1'b1;
      end
      default: begin
        ang_ready_s = 1'b0;
      end
    endcase
    if (flush) begin
      ang_ready_s    = 1'b0;
      theta_ready_s  = 1'b0;
      argmax_valid_s = 1'b0;
      eps_valid_s    = 1'b0;
    end else begin
      ang_ready_s    = ang_ready_s;
    end
    // No buffer write may leak out while the block is held in reset.
    wr_en_s      = ang_valid & ang_ready_s & ~rst;
    theta_xfer_s = theta_valid & theta_ready_s;
    eps_xfer_s   = eps_valid_s & eps_ready;
  end

  // Next-state and datapath updates; flush overrides everything last.
  always_comb begin
    state_d     = state_q;
    write_ptr_d = write_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    theta_d     = theta_q;
    eps_data_d  = eps_data_q;
    eps_cnt_d   = eps_cnt_q;
    sel_err_d   = sel_err_q;

    // Sample writes proceed in every state that advertises ang_ready,
    // so the ARMED same-cycle case also advances the pointer.
    if (wr_en_s) begin
      write_ptr_d = write_ptr_q + 8'd1;
      if (fill_cnt_q != FILL_FULL) begin
        fill_cnt_d = fill_cnt_q + 9'd1;
      end else begin
        fill_cnt_d = fill_cnt_q;
      end
    end else begin
      write_ptr_d = write_ptr_q;
    end

    case (state_q)
      ST_FILL: begin
        if (fill_cnt_d == FILL_FULL) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_ARMED: begin
        if (theta_xfer_s) begin
          theta_d = theta_in;
          state_d = ST_EVAL;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_EVAL: begin
        if (sel_valid) begin
          eps_data_d = sel_eps;
          state_d    = ST_OUT;
        end else begin
          sel_err_d  = 1'b1;
          state_d    = ST_ARMED;
        end
      end
      ST_OUT: begin
        if (eps_xfer_s) begin
          eps_cnt_d = eps_cnt_q + 16'd1;
          state_d   = ST_ARMED;
        end else begin
          state_d   = ST_OUT;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    // Restart fill; results already latched and statistics are kept.
    if (flush) begin
      state_d     = ST_FILL;
      write_ptr_d = 8'd255;
      fill_cnt_d  = 9'd0;
      eps_cnt_d   = eps_cnt_q;
      sel_err_d   = sel_err_q;
      eps_data_d  = eps_data_q;
      theta_d     = theta_q;
    end else begin
      state_d     = state_d;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      write_ptr_q <= 8'd255;
      fill_cnt_q  <= 9'd0;
      theta_q     <= '0;
      eps_data_q  <= '0;
      eps_cnt_q   <= 16'd0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_ptr_q <= write_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      theta_q     <= theta_d;
      eps_data_q  <= eps_data_d;
      eps_cnt_q   <= eps_cnt_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign ang_ready    = ang_ready_s;
  assign theta_ready  = theta_ready_s;
  assign argmax_valid = argmax_valid_s;
  assign eps_valid    = eps_valid_s;
  assign wr_en        = wr_en_s;
  assign wr_addr      = write_ptr_q + 8'd1;
  assign wr_data      = ang_in;
  assign write_ptr    = write_ptr_q;
  assign buf_valid    = (fill_cnt_q == FILL_FULL);
  assign eps_data     = eps_data_q;
  assign eps_cnt      = eps_cnt_q;
  assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_eps_ctrl.sv
// Directed testbench for eps_ctrl: fill, nominal estimate, same-cycle
// write/accept, select error, backpressure with pointer wrap, flush in OUT
// and asynchronous reset during EVAL.
module tb_eps_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ang_valid;
  logic        ang_ready;
  logic [15:0] ang_in;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  write_ptr;
  logic        buf_valid;
  logic        theta_valid;
  logic        theta_ready;
  logic [7:0]  theta_in;
  logic [7:0]  theta_q;
  logic        argmax_valid;
  logic [19:0] sel_eps;
  logic        sel_valid;
  logic        eps_valid;
  logic        eps_ready;
  logic [19:0] eps_data;
  logic [15:0] eps_cnt;
  logic        sel_err;

  int n_checks;
  int n_errors;

  eps_ctrl #(.ANG_W(16), .THETA_W(8), .EPS_W(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ang_valid    (ang_valid),
    .ang_ready    (ang_ready),
    .ang_in       (ang_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .write_ptr    (write_ptr),
    .buf_valid    (buf_valid),
    .theta_valid  (theta_valid),
    .theta_ready  (theta_ready),
    .theta_in     (theta_in),
    .theta_q      (theta_q),
    .argmax_valid (argmax_valid),
    .sel_eps      (sel_eps),
    .sel_valid    (sel_valid),
    .eps_valid    (eps_valid),
    .eps_ready    (eps_ready),
    .eps_data     (eps_data),
    .eps_cnt      (eps_cnt),
    .sel_err      (sel_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill the buffer with 256 samples starting from FILL right after restart.
  task automatic fill_buffer(input bit do_check);
    for (int i = 0; i < 256; i++) begin
      ang_valid = 1'b1;
      ang_in    = 16'(i);
      #1;
      if (do_check) begin
        check("fill_wr_addr", 32'(wr_addr), 32'(i));
        if (i == 255) check("fill_buf_valid_pre", 32'(buf_valid), 32'd0);
      end
      tick();
    end
    ang_valid = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    ang_valid   = 1'b1;
    ang_in      = 16'd0;
    theta_valid = 1'b0;
    theta_in    = 8'd0;
    sel_eps     = 20'd0;
    sel_valid   = 1'b0;
    eps_ready   = 1'b0;

    // Outputs while reset is held
    #2;
    check("rst_ang_ready",    32'(ang_ready),    32'd1);
    check("rst_theta_ready",  32'(theta_ready),  32'd0);
    check("rst_argmax_valid", 32'(argmax_valid), 32'd0);
    check("rst_eps_valid",    32'(eps_valid),    32'd0);
    check("rst_buf_valid",    32'(buf_valid),    32'd0);
    check("rst_wr_en",        32'(wr_en),        32'd0);
    check("rst_write_ptr",    32'(write_ptr),    32'd255);
    check("rst_eps_cnt",      32'(eps_cnt),      32'd0);
    check("rst_sel_err",      32'(sel_err),      32'd0);
    ang_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Fill 0..255
    fill_buffer(1'b1);
    #1;
    check("fill_write_ptr",   32'(write_ptr),   32'd255);
    check("fill_buf_valid",   32'(buf_valid),   32'd1);
    check("fill_theta_ready", 32'(theta_ready), 32'd1);

    // Nominal estimate: theta 17, eps 0x00ABC
    theta_valid = 1'b1;
    theta_in    = 8'd17;
    sel_valid   = 1'b1;
    sel_eps     = 20'h00ABC;
    eps_ready   = 1'b1;
    #1;
    check("nom_argmax_pre", 32'(argmax_valid), 32'd0);
    tick();
    theta_valid = 1'b0;
    #1;
    check("nom_argmax_valid", 32'(argmax_valid), 32'd1);
    check("nom_theta_q",      32'(theta_q),      32'd17);
    check("nom_eval_eps_val", 32'(eps_valid),    32'd0);
    check("nom_eval_ang_rdy", 32'(ang_ready),    32'd0);
    tick();
    #1;
    check("nom_argmax_once",  32'(argmax_valid), 32'd0);
    check("nom_eps_valid",    32'(eps_valid),    32'd1);
    check("nom_eps_data",     32'(eps_data),     32'h00ABC);
    tick();
    #1;
    check("nom_eps_valid_off", 32'(eps_valid),   32'd0);
    check("nom_eps_cnt",       32'(eps_cnt),     32'd1);
    check("nom_theta_ready",   32'(theta_ready), 32'd1);

    // Same-cycle write and accept with write_ptr 255, then select error
    ang_valid   = 1'b1;
    ang_in      = 16'h0055;
    theta_valid = 1'b1;
    theta_in    = 8'd3;
    sel_valid   = 1'b0;
    eps_ready   = 1'b0;
    #1;
    check("sim_wr_en",   32'(wr_en),   32'd1);
    check("sim_wr_addr", 32'(wr_addr), 32'd0);
    tick();
    theta_valid = 1'b0;
    ang_in      = 16'h0066;
    #1;
    check("sim_eval_write_ptr", 32'(write_ptr),    32'd0);
    check("sim_eval_ang_ready", 32'(ang_ready),    32'd0);
    check("sim_eval_wr_en",     32'(wr_en),        32'd0);
    check("sim_eval_argmax",    32'(argmax_valid), 32'd1);
    check("sim_eval_theta_q",   32'(theta_q),      32'd3);
    tick();
    ang_valid = 1'b0;
    #1;
    check("err_sel_err",     32'(sel_err),     32'd1);
    check("err_eps_valid",   32'(eps_valid),   32'd0);
    check("err_theta_ready", 32'(theta_ready), 32'd1);
    check("err_write_ptr",   32'(write_ptr),   32'd0);
    check("err_eps_data",    32'(eps_data),    32'h00ABC);

    // Backpressure: move write_ptr to 250, then hold OUT for 10 cycles
    for (int i = 0; i < 250; i++) begin
      ang_valid = 1'b1;
      ang_in    = 16'(i);
      tick();
    end
    ang_valid = 1'b0;
    #1;
    check("bp_pre_write_ptr", 32'(write_ptr), 32'd250);
    theta_valid = 1'b1;
    theta_in    = 8'd200;
    sel_valid   = 1'b1;
    sel_eps     = 20'h12345;
    eps_ready   = 1'b0;
    tick();
    theta_valid = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      ang_valid = 1'b1;
      ang_in    = 16'(k);
      #1;
      check("bp_eps_valid",   32'(eps_valid),   32'd1);
      check("bp_eps_data",    32'(eps_data),    32'h12345);
      check("bp_theta_ready", 32'(theta_ready), 32'd0);
      check("bp_ang_ready",   32'(ang_ready),   32'd1);
      check("bp_wr_addr",     32'(wr_addr),     32'((251 + k) % 256));
      tick();
    end
    ang_valid = 1'b0;
    eps_ready = 1'b1;
    #1;
    check("bp_wrap_write_ptr", 32'(write_ptr), 32'd4);
    check("bp_still_valid",    32'(eps_valid), 32'd1);
    tick();
    #1;
    check("bp_xfer_valid_off", 32'(eps_valid), 32'd0);
    check("bp_eps_cnt",        32'(eps_cnt),   32'd2);
    tick();
    #1;
    check("bp_single_xfer", 32'(eps_cnt), 32'd2);

    // Flush while in OUT with a simultaneous eps handshake offered
    theta_valid = 1'b1;
    theta_in    = 8'd5;
    sel_valid   = 1'b1;
    sel_eps     = 20'h00777;
    eps_ready   = 1'b0;
    tick();
    theta_valid = 1'b0;
    tick();
    #1;
    check("fl_out_valid", 32'(eps_valid), 32'd1);
    flush     = 1'b1;
    eps_ready = 1'b1;
    ang_valid = 1'b1;
    #1;
    check("fl_ang_ready", 32'(ang_ready), 32'd0);
    check("fl_wr_en",     32'(wr_en),     32'd0);
    tick();
    flush     = 1'b0;
    eps_ready = 1'b0;
    ang_valid = 1'b0;
    #1;
    check("fl_eps_valid",   32'(eps_valid),   32'd0);
    check("fl_buf_valid",   32'(buf_valid),   32'd0);
    check("fl_write_ptr",   32'(write_ptr),   32'd255);
    check("fl_eps_cnt",     32'(eps_cnt),     32'd2);
    check("fl_sel_err",     32'(sel_err),     32'd1);
    check("fl_theta_ready", 32'(theta_ready), 32'd0);
    check("fl_eps_data",    32'(eps_data),    32'h00777);

    // Async reset pulsed between edges during EVAL
    tick();
    fill_buffer(1'b0);
    #1;
    check("ar_armed", 32'(theta_ready), 32'd1);
    theta_valid = 1'b1;
    theta_in    = 8'd9;
    sel_valid   = 1'b1;
    sel_eps     = 20'h0BEEF;
    eps_ready   = 1'b1;
    tick();
    theta_valid = 1'b0;
    #1;
    check("ar_eval_argmax", 32'(argmax_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_argmax",    32'(argmax_valid), 32'd0);
    check("ar_write_ptr", 32'(write_ptr),    32'd255);
    check("ar_buf_valid", 32'(buf_valid),    32'd0);
    check("ar_theta_q",   32'(theta_q),      32'd0);
    check("ar_eps_data",  32'(eps_data),     32'd0);
    check("ar_eps_cnt",   32'(eps_cnt),      32'd0);
    check("ar_sel_err",   32'(sel_err),      32'd0);
    #1;
    rst = 1'b0;
    tick();
    #1;
    check("ar_no_eps_valid", 32'(eps_valid),   32'd0);
    check("ar_no_eps_cnt",   32'(eps_cnt),     32'd0);
    check("ar_fill_state",   32'(theta_ready), 32'd0);
    tick();
    #1;
    check("ar_no_eps_valid2", 32'(eps_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
